// File: rtl/wb_pkg.sv
// Shared widths, entry type and sizing helpers for the register-file write-back queue.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 16;
  localparam int unsigned WB_ADDR_W = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // Pointer width; at least one bit even for a degenerate single-entry queue.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width; must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Finds the youngest queued entry whose destination matches one read address.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PW     = ptr_w(DEPTH),
  parameter int unsigned CW     = cnt_w(DEPTH)
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
  input  logic [DEPTH-1:0]             entry_valid,
  input  logic [PW-1:0]                rd_ptr,
  input  logic [CW-1:0]                count,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  logic [PW-1:0] idx;

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && entry_valid[idx] && (entry_addr[idx] == rd_addr)) begin
        hit  = 1'b1;
        data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue between execute and the register file write port,
// with youngest-entry forwarding for two operand-fetch read addresses.
module regfile_wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PW    = ptr_w(DEPTH),
  localparam int unsigned CW    = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,

  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,

  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,

  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [DATA_W-1:0] rf_write_data,

  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              fwd_valid1,
  output logic              fwd_valid2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,

  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;

  logic              push_mem, push_alu, push, pop;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Load path has fixed priority; no pass-through when full, even if retiring.
  assign mem_ready = !full && !flush;
  assign alu_ready = !full && !flush && !mem_valid;

  assign push_mem  = mem_valid && mem_ready;
  assign push_alu  = alu_valid && alu_ready;
  assign push      = push_mem || push_alu;
  assign push_addr = push_mem ? mem_addr : alu_addr;
  assign push_data = push_mem ? mem_data : alu_data;

  assign rf_write_en      = !empty && !flush;
  assign rf_write_address = addr_q[rd_ptr_q];
  assign rf_write_data    = data_q[rd_ptr_q];
  assign pop              = rf_write_en;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // push and pop never share a slot: push needs !full, pop needs !empty
      if (push) begin
        addr_d[wr_ptr_q]  = push_addr;
        data_d[wr_ptr_q]  = push_data;
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  wb_fwd_match #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PW     (PW),
    .CW     (CW)
  ) u_fwd1 (
    .entry_addr  (addr_q),
    .entry_data  (data_q),
    .entry_valid (valid_q),
    .rd_ptr      (rd_ptr_q),
    .count       (count_q),
    .rd_addr     (rd_addr1),
    .hit         (fwd_valid1),
    .data        (fwd_data1)
  );

  wb_fwd_match #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PW     (PW),
    .CW     (CW)
  ) u_fwd2 (
    .entry_addr  (addr_q),
    .entry_data  (data_q),
    .entry_valid (valid_q),
    .rd_ptr      (rd_ptr_q),
    .count       (count_q),
    .rd_addr     (rd_addr2),
    .hit         (fwd_valid2),
    .data        (fwd_data2)
  );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: stimulus pushes expected retirements,
// an independent monitor pops and compares whenever the DUT writes the register file.
module tb_regfile_wb_queue;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data;
  logic        rf_write_en;
  logic [3:0]  rf_write_address;
  logic [15:0] rf_write_data;
  logic [3:0]  rd_addr1, rd_addr2;
  logic        fwd_valid1, fwd_valid2;
  logic [15:0] fwd_data1, fwd_data2;
  logic [2:0]  count;
  logic        full, empty;

  int vectors;
  int miscompares;

  wb_entry_t   exp_q[$];
  logic [3:0]  last_addr;

  regfile_wb_queue #(
    .DATA_W (16),
    .ADDR_W (4),
    .DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_addr         (alu_addr),
    .alu_data         (alu_data),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_addr         (mem_addr),
    .mem_data         (mem_data),
    .rf_write_en      (rf_write_en),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .rd_addr1         (rd_addr1),
    .rd_addr2         (rd_addr2),
    .fwd_valid1       (fwd_valid1),
    .fwd_valid2       (fwd_valid2),
    .fwd_data1        (fwd_data1),
    .fwd_data2        (fwd_data2),
    .count            (count),
    .full             (full),
    .empty            (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Youngest pending write to an address, from the reference queue.
  task automatic model_fwd(input logic [3:0] a, output logic hit, output logic [15:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].addr == a) begin
        hit = 1'b1;
        d   = exp_q[i].data;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wen", 32'(rf_write_en), 32'd0);
    chk("rst_waddr", 32'(rf_write_address), 32'd0);
    chk("rst_wdata", 32'(rf_write_data), 32'd0);
    chk("rst_fwd_v1", 32'(fwd_valid1), 32'd0);
    chk("rst_fwd_v2", 32'(fwd_valid2), 32'd0);
    chk("rst_fwd_d1", 32'(fwd_data1), 32'd0);
    chk("rst_fwd_d2", 32'(fwd_data2), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic do_cycle(input logic mv, input logic [3:0] ma, input logic [15:0] md,
                          input logic av, input logic [3:0] aa, input logic [15:0] ad,
                          input logic fl, input logic [3:0] r1, input logic [3:0] r2);
    logic        exp_mrdy, exp_ardy, h;
    logic [15:0] d;
    int          sz;
    wb_entry_t   e;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    flush = fl; rd_addr1 = r1; rd_addr2 = r2;
    #1;
    sz       = exp_q.size();
    exp_mrdy = (sz < DEPTH) && !fl;
    exp_ardy = exp_mrdy && !mv;
    chk("mem_ready", 32'(mem_ready), 32'(exp_mrdy));
    chk("alu_ready", 32'(alu_ready), 32'(exp_ardy));
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    model_fwd(r1, h, d);
    chk("fwd_valid1", 32'(fwd_valid1), 32'(h));
    chk("fwd_data1", 32'(fwd_data1), 32'(d));
    model_fwd(r2, h, d);
    chk("fwd_valid2", 32'(fwd_valid2), 32'(h));
    chk("fwd_data2", 32'(fwd_data2), 32'(d));
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else if (mv && exp_mrdy) begin
      e.addr = ma; e.data = md; exp_q.push_back(e); last_addr = ma;
    end else if (av && exp_ardy) begin
      e.addr = aa; e.data = ad; exp_q.push_back(e); last_addr = aa;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle(input logic [3:0] r1);
    do_cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, r1, 4'd0);
  endtask

  // Monitor: every retirement the DUT presents must be the oldest expected entry.
  initial begin
    wb_entry_t e;
    logic      exp_en;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        exp_en = (exp_q.size() > 0) && !flush;
        chk("rf_write_en", 32'(rf_write_en), 32'(exp_en));
        if (rf_write_en && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rf_write_address", 32'(rf_write_address), 32'(e.addr));
          chk("rf_write_data", 32'(rf_write_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        mv, av, fl;
    logic [3:0]  ma, aa, r1, r2;
    logic [15:0] md, ad;
    vectors = 0;
    miscompares = 0;
    last_addr = 4'd0;
    rst_n = 1'b0;
    flush = 1'b0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h1234;
    rd_addr1 = 4'd3; rd_addr2 = 4'd0;
    #3;
    check_reset_outputs();
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);

    // Release reset, first entry accepted at edge 1, written in cycle 2.
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd3, 4'd3);
    idle_cycle(4'd3);
    idle_cycle(4'd3);

    // Both sources valid: load path wins, ALU follows.
    do_cycle(1'b1, 4'd2, 16'h5555, 1'b1, 4'd1, 16'hAAAA, 1'b0, 4'd2, 4'd1);
    do_cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'd1, 16'hAAAA, 1'b0, 4'd2, 4'd1);
    idle_cycle(4'd1);

    // Same register written twice back-to-back.
    do_cycle(1'b1, 4'd5, 16'h0001, 1'b0, 4'd0, 16'd0, 1'b0, 4'd5, 4'd5);
    do_cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'h0002, 1'b0, 4'd5, 4'd5);
    idle_cycle(4'd5);
    idle_cycle(4'd5);

    // Flush with an entry queued and a load waiting.
    do_cycle(1'b1, 4'd9, 16'h0909, 1'b0, 4'd0, 16'd0, 1'b0, 4'd9, 4'd0);
    do_cycle(1'b1, 4'd6, 16'h0606, 1'b0, 4'd0, 16'd0, 1'b1, 4'd9, 4'd6);
    do_cycle(1'b1, 4'd6, 16'h0606, 1'b0, 4'd0, 16'd0, 1'b0, 4'd9, 4'd6);
    idle_cycle(4'd6);

    // Sustained one-per-cycle stream across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      do_cycle(i[0], 4'(i), 16'(16'h1000 + i), 1'b1, 4'(i + 8), 16'(16'h2000 + i),
               1'b0, 4'(i), 4'(i + 8));
    end
    idle_cycle(4'd0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      mv = ($urandom % 3) == 0;
      av = ($urandom % 2) == 1;
      fl = ($urandom % 20) == 0;
      ma = 4'($urandom);
      aa = 4'($urandom);
      md = 16'($urandom);
      ad = 16'($urandom);
      r1 = ($urandom % 2 == 1) ? last_addr : 4'($urandom);
      r2 = 4'($urandom);
      do_cycle(mv, ma, md, av, aa, ad, fl, r1, r2);
    end
    idle_cycle(4'd0);

    // Asynchronous reset in the middle of a retirement.
    do_cycle(1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd0, 16'd0, 1'b0, 4'd7, 4'd7);
    mem_valid = 1'b0; alu_valid = 1'b0; flush = 1'b0;
    rd_addr1 = 4'd7; rd_addr2 = 4'd7;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle(4'd7);
    do_cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'd4, 16'h4444, 1'b0, 4'd4, 4'd7);
    idle_cycle(4'd4);
    idle_cycle(4'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
